// File: rtl/logic_issue_unit_pkg.sv
// rtl/logic_issue_unit_pkg.sv - shared constants, state encoding and field helpers for logic_issue_unit
//
// Purpose : opcode/funct constants, FSM state type and instruction field
//           positions shared by the logic issue unit and its register file.
// Ports   : none (package).
package logic_issue_unit_pkg;

    localparam logic [3:0] OP_LOGIC = 4'b0010;
    localparam logic [3:0] OP_LDI   = 4'b0001;

    localparam logic [1:0] FN_AND = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_XOR = 2'b10;
    localparam logic [1:0] FN_NOT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_e;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int FN_LSB  = 0;
    localparam int IMM_W   = 9;

    function automatic logic [3:0] f_opcode(input logic [15:0] instr);
        return instr[OPC_LSB +: 4];
    endfunction

    function automatic logic [2:0] f_rd(input logic [15:0] instr);
        return instr[RD_LSB +: 3];
    endfunction

    function automatic logic [2:0] f_rs1(input logic [15:0] instr);
        return instr[RS1_LSB +: 3];
    endfunction

    function automatic logic [2:0] f_rs2(input logic [15:0] instr);
        return instr[RS2_LSB +: 3];
    endfunction

    function automatic logic [1:0] f_funct(input logic [15:0] instr);
        return instr[FN_LSB +: 2];
    endfunction

    // imm9 is zero-extended to the 16-bit datapath width.
    function automatic logic [15:0] f_imm(input logic [15:0] instr);
        return {{(16 - IMM_W){1'b0}}, instr[IMM_W-1:0]};
    endfunction

endpackage

// File: rtl/logic_issue_unit_regfile.sv
// rtl/logic_issue_unit_regfile.sv - 8x16 register file with two read ports and a debug port
//
// Purpose : general-purpose registers r0..r7 (none hardwired).
// Ports   : clk, rst_n (sync clear, active-low), we_i/waddr_i/wdata_i write
//           port, raddr1_i/rdata1_o and raddr2_i/rdata2_o combinational reads,
//           dbg_addr_i/dbg_data_o combinational debug read.
module regfile_8x16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [2:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [2:0]  raddr1_i,
    output logic [15:0] rdata1_o,
    input  logic [2:0]  raddr2_i,
    output logic [15:0] rdata2_o,
    input  logic [2:0]  dbg_addr_i,
    output logic [15:0] dbg_data_o
);

    logic [15:0] regs_q [8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o   = regs_q[raddr1_i];
    assign rdata2_o   = regs_q[raddr2_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/logic_issue_unit.sv
// rtl/logic_issue_unit.sv - three-state issue front end for the external 16-bit bitwise unit
//
// Purpose : accepts instruction words, reads operands, drives the external
//           bitwise unit, samples its result and writes it back.
// Ports   : clk, rst_n (sync, active-low); in_valid/in_ready/in_instr
//           instruction handshake; bw_a/bw_b/bw_funct/bw_out bitwise unit
//           interface; done/illegal/result retire strobe; dbg_addr/dbg_data
//           debug register read; zflag (only with LOGIC_ISSUE_ZFLAG_EN).
// Config  : LOGIC_ISSUE_ZFLAG_EN adds the registered zero flag output.
module logic_issue_unit #(
    parameter logic [3:0] OP_LOGIC = logic_issue_unit_pkg::OP_LOGIC,
    parameter logic [3:0] OP_LDI   = logic_issue_unit_pkg::OP_LDI
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef LOGIC_ISSUE_ZFLAG_EN
    output logic        zflag,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [15:0] bw_a,
    output logic [15:0] bw_b,
    output logic [1:0]  bw_funct,
    input  logic [15:0] bw_out,
    output logic        done,
    output logic        illegal,
    output logic [15:0] result,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    import logic_issue_unit_pkg::*;

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] res_q, res_d;

    logic        is_logic, is_ldi, is_legal;
    logic        in_issue, in_wb, rf_we;
    logic [15:0] rdata1, rdata2;

    assign is_logic = (f_opcode(instr_q) == OP_LOGIC);
    assign is_ldi   = (f_opcode(instr_q) == OP_LDI);
    assign is_legal = is_logic || is_ldi;

    assign in_issue = (state_q == ST_ISSUE);
    assign in_wb    = (state_q == ST_WB);
    assign rf_we    = in_wb && is_legal;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (is_logic) begin
                    res_d = bw_out;
                end else if (is_ldi) begin
                    res_d = f_imm(instr_q);
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= 16'h0000;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            res_q   <= res_d;
        end
    end

`ifdef LOGIC_ISSUE_ZFLAG_EN
    logic zflag_q;

    // Illegal instructions leave the flag untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zflag_q <= 1'b0;
        end else if (rf_we) begin
            zflag_q <= (res_q == 16'h0000);
        end
    end

    assign zflag = zflag_q;
`endif

    regfile_8x16 u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (rf_we),
        .waddr_i    (f_rd(instr_q)),
        .wdata_i    (res_q),
        .raddr1_i   (f_rs1(instr_q)),
        .rdata1_o   (rdata1),
        .raddr2_i   (f_rs2(instr_q)),
        .rdata2_o   (rdata2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // The bitwise unit sees operands only while the instruction is issuing;
    // operand B is driven even for NOT, the unit simply ignores it.
    assign in_ready = (state_q == ST_IDLE);
    assign bw_a     = in_issue ? rdata1 : 16'h0000;
    assign bw_b     = in_issue ? rdata2 : 16'h0000;
    assign bw_funct = in_issue ? f_funct(instr_q) : 2'b00;

    assign done     = in_wb;
    assign illegal  = in_wb && !is_legal;
    assign result   = rf_we ? res_q : 16'h0000;

endmodule

// File: doc/logic_issue_unit.md
# logic_issue_unit

- Sequential front end that drives the combinational 16-bit bitwise unit (AND/OR/XOR/NOT) from the issuing side.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal 8×16 register file, presents `a`/`b`/`funct` to the bitwise unit, samples its result and writes it back.
- Sits between instruction fetch and the logic datapath of the 16-bit core.

## Interface
Parameters:
- `OP_LOGIC`, 4'b0010: opcode of the logic class.
- `OP_LDI`, 4'b0001: opcode of load-immediate.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: instruction word valid.
- `in_ready` output 1: unit can accept an instruction.
- `in_instr` input 16: instruction word.
- `bw_a` output 16: operand A to the bitwise unit.
- `bw_b` output 16: operand B to the bitwise unit.
- `bw_funct` output 2: function select: 00 AND, 01 OR, 10 XOR, 11 NOT A.
- `bw_out` input 16: combinational result from the bitwise unit.
- `done` output 1: one-cycle pulse when an instruction retires.
- `illegal` output 1: one-cycle pulse, coincident with `done`, for an undefined opcode.
- `result` output 16: value written back, valid while `done` is high.
- `dbg_addr` input 3: debug register read address.
- `dbg_data` output 16: combinational read of `regfile[dbg_addr]`.

## Operation
- Instruction fields:
  - [15:12] opcode
  - [11:9] rd
  - [8:6] rs1
  - [5:3] rs2
  - [1:0] funct
  - [2] ignored
  - LDI uses [8:0] as imm9, zero-extended to 16 bits.
- FSM states: IDLE, ISSUE, WB.
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch the instruction and go to ISSUE.
  - ISSUE: `in_ready`=0.
    - Logic op: drive `bw_a`=reg[rs1], `bw_b`=reg[rs2], `bw_funct`=funct; capture `bw_out` into the result register at the end of the cycle.
    - LDI: capture imm9 zero-extended.
    - Other opcodes: capture nothing.
    - Go to WB.
  - WB: `in_ready`=0. Pulse `done`.
    - LDI/logic: write the result to reg[rd]; `result` shows the value.
    - Illegal: no register write, `illegal`=1, `result`=0.
    - Go to IDLE.
- Outside ISSUE, `bw_a`/`bw_b`/`bw_funct` are held at 0.
- For funct 11, `bw_b` is still driven (the unit ignores it).
- rd may equal rs1 or rs2. Operands are read in ISSUE and written in WB, so no hazard exists.
- All 8 registers are general purpose; r0 is not hardwired.
- `dbg_data` reflects a WB write from the cycle after the write edge.

## Timing
- Reset values:
  - state=IDLE, so `in_ready`=1.
  - `done`=0, `illegal`=0, `result`=0.
  - `bw_a`=`bw_b`=0, `bw_funct`=0.
  - All registers =0.
- Latency: handshake edge at cycle 0; ISSUE in cycle 1; WB in cycle 2 with `done`; register updated at the end of cycle 2; `in_ready` high again in cycle 3.
- Throughput: one instruction per 3 cycles.
- `in_valid` without `in_ready` is ignored. The source must hold `in_instr` stable until the handshake.
- `rst_n` low during ISSUE or WB:
  - The in-flight instruction is discarded and no write occurs.
  - The register file clears.
  - All outputs take their reset values on that edge.
- Reset dominates every other event on the same edge.

## Configuration
- `LOGIC_ISSUE_ZFLAG_EN`:
  - Defined: adds output `zflag` (1 bit). It is registered and updated in WB of logic and LDI instructions to (result==0). It holds its value across illegal instructions and resets to 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - the opcode constants `OP_LOGIC` and `OP_LDI`;
  - the funct encodings `FN_AND`=00, `FN_OR`=01, `FN_XOR`=10, `FN_NOT`=11;
  - the state encoding (IDLE, ISSUE, WB);
  - the instruction field bit positions.
- One natural sub-module: `regfile_8x16`, with one synchronous write port, two combinational read ports plus a debug read port, and synchronous clear on `rst_n` low.
- The bitwise unit stays external; the bench instantiates it, or a model of it, on the `bw_*` ports.

## Test plan
- Reset, then LDI r1,0x0F0 and LDI r2,0x0FF -> `done` pulses with `result` 0x00F0 and 0x00FF; `dbg_data`(r1)=0x00F0.
- With r1=0x00F0 and r2=0x00FF: funct 00 r3 -> 0x00F0; 01 r4 -> 0x00FF; 10 r5 -> 0x000F; 11 r6 -> 0xFF0F; `bw_funct` is observed in ISSUE only.
- Back-to-back `in_valid` held high -> accepts at cycles 0, 3, 6; `in_ready` is low in cycles 1–2 and 4–5.
- Opcode 4'b1111 -> `done`=1 and `illegal`=1 in WB, `result`=0, all registers unchanged.
- `rst_n` low during ISSUE of XOR r1,r1,r2 -> no `done`, all registers 0, `in_ready`=1 the next cycle.
- With `LOGIC_ISSUE_ZFLAG_EN` defined: XOR r7,r1,r1 -> `result`=0 and `zflag`=1; then OR r7,r1,r2 -> `zflag`=0.
